// File: rtl/fifo_array_ctrl.sv
// fifo_array_ctrl
// Sequences one tile through the IFMAP/filter FIFO array that feeds the
// systolic array. In FILL, each accepted loader vector is written into all
// M+N FIFOs at once. In DRAIN, read enables are issued either diagonally
// skewed (lane k starts k cycles after lane 0) or in lockstep. The block also
// flags protocol violations against the array's full/empty flags.
//
// Build option: define FIFO_CTRL_SKEW_EN for diagonal skew.
//   FIFO_CTRL_SKEW_EN defined   : drain length D = LEN + max(M,N) - 1
//   FIFO_CTRL_SKEW_EN undefined : all lanes read together, D = LEN
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a tile (only honoured in IDLE)
//   in_valid/in_ready loader handshake during FILL
//   fifo_full/empty   flags from the FIFO array, [M-1:0] IFMAP, [M+N-1:M] filter
//   wr_en, rd_en      FIFO write/read enables, same bit map as the flags
//   lane_valid        rd_en delayed one cycle (FIFO data_out is registered)
//   busy, done, err   status: not idle, tile-complete pulse, sticky error
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// FILL  | writing LEN vectors into every FIFO
// DRAIN | issuing (optionally skewed) read enables, cyc counts 0..D-1
// DONE  | one-cycle done pulse, then back to IDLE
module fifo_array_ctrl #(
  parameter int M     = 8,
  parameter int N     = 8,
  parameter int DEPTH = 8,
  parameter int LEN   = DEPTH,
  parameter int CW    = $clog2(LEN + ((M > N) ? M : N) + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M+N-1:0]   fifo_full,
  input  logic [M+N-1:0]   fifo_empty,
  output logic [M+N-1:0]   wr_en,
  output logic [M+N-1:0]   rd_en,
  output logic [M+N-1:0]   lane_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef FIFO_CTRL_SKEW_EN
  localparam int MAXMN = (M > N) ? M : N;
  localparam int D     = LEN + MAXMN - 1;
`else
  localparam int D     = LEN;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] cyc;
  logic          hs;
  logic          viol;

  assign in_ready = (state == S_FILL) && !(|fifo_full);
  assign hs       = in_ready && in_valid;
  assign wr_en    = {(M+N){hs}};

  // Lane k is active while 0 <= cyc - ofs < LEN. The subtraction is done one
  // bit wider so a negative difference shows up as the top bit, which avoids
  // a constant "cyc >= 0" compare on lane 0.
  for (genvar k = 0; k < M + N; k++) begin : g_rd
`ifdef FIFO_CTRL_SKEW_EN
    localparam int OFS = (k < M) ? k : k - M;
`else
    localparam int OFS = 0;
`endif
    logic [CW:0] diff;
    assign diff     = {1'b0, cyc} - (CW+1)'(OFS);
    assign rd_en[k] = (state == S_DRAIN) && !diff[CW] && (diff[CW-1:0] < CW'(LEN));
  end

  // wr_en is only raised when no full flag is set, so the full-side check
  // guards against integration mistakes rather than normal traffic.
  assign viol = (|(rd_en & fifo_empty)) || (|(wr_en & fifo_full));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_cnt     <= '0;
      cyc        <= '0;
      lane_valid <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      lane_valid <= rd_en;
      done       <= 1'b0;
      if (viol) err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_FILL;
            wr_cnt <= '0;
            cyc    <= '0;
            err    <= 1'b0;
            busy   <= 1'b1;
          end
        end
        S_FILL: begin
          if (hs) begin
            wr_cnt <= wr_cnt + CW'(1);
            if (wr_cnt == CW'(LEN - 1)) begin
              state <= S_DRAIN;
              cyc   <= '0;
            end
          end
        end
        S_DRAIN: begin
          cyc <= cyc + CW'(1);
          if (cyc == CW'(D - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
